// File: rtl/led_cmd_sequencer.sv
// Host-side sequencer for the 20-LED controller: buffers 8-bit commands in a FIFO and
// serialises each valid one MSB first onto DATA/CLK/LATCH at a DIV-cycle phase rate.
module led_cmd_sequencer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned DIV      = 4,
  parameter int unsigned NUM_LEDS = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] CMD,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  output logic       SR_DATA,
  output logic       SR_CLK,
  output logic       SR_LATCH,
  output logic       BUSY,
  output logic       ERR
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PhW  = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CntW-1:0] Full     = CntW'(DEPTH);
  localparam logic [PhW-1:0]  PhLast   = PhW'(DIV - 1);
  localparam logic [5:0]      NumLedsW = 6'(NUM_LEDS);

  typedef enum logic [2:0] {StIdle, StShiftLo, StShiftHi, StLatch, StGap} state_e;

  state_e          state_q, state_d;
  logic [PhW-1:0]  phase_q, phase_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [6:0]      shift_q, shift_d;
  logic            sr_data_q, sr_data_d;
  logic            sr_clk_q, sr_clk_d;
  logic            sr_latch_q, sr_latch_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic            push, pop, empty, full, addr_ok, phase_last;
  logic [7:0]      head;

  assign empty      = (count_q == '0);
  assign full       = (count_q == Full);
  assign push       = CMD_VALID && !full;
  assign head       = mem_q[rd_ptr_q];
  assign addr_ok    = ({1'b0, head[4:0]} < NumLedsW);
  assign phase_last = (phase_q == PhLast);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    sr_data_d  = sr_data_q;
    sr_clk_d   = sr_clk_q;
    sr_latch_d = sr_latch_q;
    err_d      = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop = 1'b1;
          if (addr_ok) begin
            shift_d   = head[6:0];
            bit_idx_d = 3'd7;
            sr_data_d = head[7];
            sr_clk_d  = 1'b0;
            phase_d   = '0;
            state_d   = StShiftLo;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StShiftLo: begin
        if (phase_last) begin
          phase_d  = '0;
          sr_clk_d = 1'b1;
          state_d  = StShiftHi;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StShiftHi: begin
        if (phase_last) begin
          phase_d  = '0;
          sr_clk_d = 1'b0;
          if (bit_idx_q != 3'd0) begin
            bit_idx_d = bit_idx_q - 3'd1;
            sr_data_d = shift_q[6];
            shift_d   = {shift_q[5:0], 1'b0};
            state_d   = StShiftLo;
          end else begin
            sr_data_d  = 1'b0;
            sr_latch_d = 1'b1;
            state_d    = StLatch;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StLatch: begin
        if (phase_last) begin
          phase_d    = '0;
          sr_latch_d = 1'b0;
          state_d    = StGap;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StGap: begin
        if (phase_last) begin
          phase_d = '0;
          state_d = StIdle;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    // BUSY is registered from next-state so it matches the state it describes
    busy_d = (state_d != StIdle) || (count_d != '0);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= StIdle;
      phase_q    <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      sr_data_q  <= 1'b0;
      sr_clk_q   <= 1'b0;
      sr_latch_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      sr_data_q  <= sr_data_d;
      sr_clk_q   <= sr_clk_d;
      sr_latch_q <= sr_latch_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= CMD;
    end
  end

  assign CMD_READY = !full;
  assign SR_DATA   = sr_data_q;
  assign SR_CLK    = sr_clk_q;
  assign SR_LATCH  = sr_latch_q;
  assign BUSY      = busy_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_led_cmd_sequencer.sv
// Bench for led_cmd_sequencer: a DIV=4 and a DIV=1 instance, each checked every cycle
// against a frame-timing model, plus directed scenarios with literal expectations.
module tb_led_cmd_sequencer;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned NUM_LEDS = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] cmd_s [2];
  logic [1:0] valid_s = '0;
  logic [1:0] ready_w, sr_data_w, sr_clk_w, sr_latch_w, busy_w, err_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int g, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h at %0t", name, g, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_inst
    localparam int unsigned D = (g == 0) ? 4 : 1;

    led_cmd_sequencer #(
      .DEPTH    (DEPTH),
      .DIV      (D),
      .NUM_LEDS (NUM_LEDS)
    ) u_dut (
      .CLK       (clk),
      .RESET     (rst_n),
      .CMD       (cmd_s[g]),
      .CMD_VALID (valid_s[g]),
      .CMD_READY (ready_w[g]),
      .SR_DATA   (sr_data_w[g]),
      .SR_CLK    (sr_clk_w[g]),
      .SR_LATCH  (sr_latch_w[g]),
      .BUSY      (busy_w[g]),
      .ERR       (err_w[g])
    );

    // Model: queue of accepted commands, plus time t into the current frame
    logic [7:0] q [$];
    logic [7:0] cur = '0;
    int         t = 0;
    bit         in_frame = 0;
    bit         e_err = 0;
    bit         m_valid = 0;
    bit         acc;

    always @(posedge clk) begin
      if (!rst_n) begin
        q.delete();
        in_frame = 0;
        t        = 0;
        e_err    = 0;
        m_valid  = 1;
      end else begin
        acc   = valid_s[g] && (q.size() < DEPTH);
        e_err = 0;
        if (in_frame) begin
          t++;
          if (t == 18 * D) in_frame = 0;
        end else if (q.size() > 0) begin
          cur = q.pop_front();
          if (cur[4:0] >= NUM_LEDS) e_err = 1;
          else begin
            in_frame = 1;
            t        = 0;
          end
        end
        if (acc) q.push_back(cmd_s[g]);
      end
    end

    bit e_clk, e_data, e_latch, p_clk, p_data;
    bit p_seen = 0;

    always @(negedge clk) begin
      if (m_valid) begin
        e_clk   = in_frame && (t < 16 * D) && ((t % (2 * D)) >= D);
        e_data  = 0;
        if (in_frame && (t < 16 * D)) e_data = cur[7 - t / (2 * D)];
        e_latch = in_frame && (t >= 16 * D) && (t < 17 * D);
        chk("ready", g, ready_w[g], q.size() < DEPTH);
        chk("sr_data", g, sr_data_w[g], e_data);
        chk("sr_clk", g, sr_clk_w[g], e_clk);
        chk("sr_latch", g, sr_latch_w[g], e_latch);
        chk("busy", g, busy_w[g], in_frame || (q.size() > 0));
        chk("err", g, err_w[g], e_err);
        chk("latch_with_clk", g, sr_latch_w[g] && sr_clk_w[g], 0);
        if (p_seen && p_clk && sr_clk_w[g])
          chk("data_change_clk_hi", g, sr_data_w[g], p_data);
        p_clk  = sr_clk_w[g];
        p_data = sr_data_w[g];
        p_seen = 1;
      end
    end
  end

  // Frame decoder on instance 0: bytes delivered to the controller on each LATCH rise
  logic [7:0] obs0 [$];
  logic [7:0] dec_sh = '0;
  int         dec_nb = 0;
  int         dec_bad = 0;
  bit         dec_pc = 0, dec_pl = 0;

  always @(negedge clk) begin
    if (busy_w[0] !== 1'b1) dec_nb = 0;
    if (sr_clk_w[0] === 1'b1 && !dec_pc) begin
      dec_sh = {dec_sh[6:0], sr_data_w[0]};
      dec_nb++;
    end
    if (sr_latch_w[0] === 1'b1 && !dec_pl) begin
      if (dec_nb == 8) obs0.push_back(dec_sh);
      else dec_bad++;
      dec_nb = 0;
    end
    dec_pc = (sr_clk_w[0] === 1'b1);
    dec_pl = (sr_latch_w[0] === 1'b1);
  end

  // Start right after the pop edge; k counts sampled cycles from 1
  task automatic capture(input int g, input int max_k, output logic [7:0] bits,
                         output int nr, output int first, output int sp, output int sp_bad,
                         output int lw, output int ec, output int blk);
    int last;
    bit pc;
    last = 0; pc = 0; bits = '0; nr = 0; first = 0; sp = 0; sp_bad = 0;
    lw = 0; ec = 0; blk = 0;
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clk);
      if (sr_clk_w[g] && !pc) begin
        bits = {bits[6:0], sr_data_w[g]};
        if (nr == 0) first = k;
        else if (nr == 1) sp = k - last;
        else if (k - last != sp) sp_bad = 1;
        last = k;
        nr++;
      end
      pc = sr_clk_w[g];
      if (sr_latch_w[g]) lw++;
      if (err_w[g]) ec++;
      if (!busy_w[g]) begin
        blk = k;
        break;
      end
    end
  endtask

  // Assumes the caller is at a negedge; returns at the negedge after the push edge
  task automatic push_one(input int g, input logic [7:0] c);
    cmd_s[g]   = c;
    valid_s[g] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_s[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g, input int budget, input string name);
    int n;
    n = 0;
    while (busy_w[g] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, g, busy_w[g], 0);
  endtask

  logic [7:0] bits;
  int nr, first, sp, sp_bad, lw, ec, blk;
  logic [7:0] list5 [5] = '{8'h61, 8'h82, 8'hA3, 8'hC4, 8'hE5};
  logic [7:0] exp_obs [8] = '{8'hA5, 8'h23, 8'h41, 8'h61, 8'h82, 8'hA3, 8'hC4, 8'hE5};

  initial begin
    cmd_s[0] = '0;
    cmd_s[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int g = 0; g < 2; g++) begin
      chk("rst_ready", g, ready_w[g], 1);
      chk("rst_busy", g, busy_w[g], 0);
      chk("rst_outs", g, {sr_data_w[g], sr_clk_w[g], sr_latch_w[g], err_w[g]}, 0);
    end

    // A5 into idle DIV=4 instance
    push_one(0, 8'hA5);
    @(posedge clk);
    capture(0, 200, bits, nr, first, sp, sp_bad, lw, ec, blk);
    chk("t1_rises", 0, nr, 8);
    chk("t1_bits", 0, bits, 8'hA5);
    chk("t1_first_rise", 0, first, 5);
    chk("t1_spacing", 0, sp, 8);
    chk("t1_spacing_even", 0, sp_bad, 0);
    chk("t1_latch_width", 0, lw, 4);
    chk("t1_busy_low", 0, blk, 73);
    chk("t1_no_err", 0, ec, 0);

    // Out-of-range address then a valid command
    cmd_s[0]   = 8'h14;
    valid_s[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_s[0] = 8'h23;
    @(posedge clk);
    @(negedge clk);
    valid_s[0] = 1'b0;
    chk("t3_err_pulse", 0, err_w[0], 1);
    chk("t3_err_quiet", 0, {sr_clk_w[0], sr_latch_w[0]}, 0);
    @(posedge clk);
    capture(0, 200, bits, nr, first, sp, sp_bad, lw, ec, blk);
    chk("t3_bits", 0, bits, 8'h23);
    chk("t3_rises", 0, nr, 8);
    chk("t3_err_one_cycle", 0, ec, 0);
    chk("t3_latch_width", 0, lw, 4);

    // DIV=1 frame timing
    push_one(1, 8'hC9);
    @(posedge clk);
    capture(1, 100, bits, nr, first, sp, sp_bad, lw, ec, blk);
    chk("t6_bits", 1, bits, 8'hC9);
    chk("t6_first_rise", 1, first, 2);
    chk("t6_spacing", 1, sp, 2);
    chk("t6_spacing_even", 1, sp_bad, 0);
    chk("t6_latch_width", 1, lw, 1);
    chk("t6_frame_len", 1, blk, 19);

    // Five pushes while busy; the fifth waits for the full-FIFO pop
    begin
      int i, stall, guard;
      bit full_seen;
      push_one(0, 8'h41);
      @(posedge clk);
      i = 0; stall = 0; guard = 0; full_seen = 0;
      while (i < 5 && guard < 400) begin
        @(negedge clk);
        cmd_s[0]   = list5[i];
        valid_s[0] = 1'b1;
        if (i == 4 && !full_seen) begin
          full_seen = 1;
          chk("t2_ready_full", 0, ready_w[0], 0);
        end
        if (ready_w[0]) i++;
        else stall++;
        guard++;
        @(posedge clk);
      end
      @(negedge clk);
      valid_s[0] = 1'b0;
      chk("t2_accepted", 0, i, 5);
      chk("t2_stalled", 0, stall > 0, 1);
    end
    wait_idle(0, 2000, "t2_drain");
    chk("t2_frame_count", 0, obs0.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < obs0.size()) chk("t2_frame_order", 0, obs0[k], exp_obs[k]);
    chk("t2_bad_frames", 0, dec_bad, 0);

    // Reset during the 4th SHIFT_HI with two entries queued
    begin
      int rises, guard;
      bit pc;
      cmd_s[0]   = 8'h47;
      valid_s[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cmd_s[0] = 8'h08;
      @(posedge clk);
      @(negedge clk);
      cmd_s[0] = 8'h10;
      @(posedge clk);
      @(negedge clk);
      valid_s[0] = 1'b0;
      rises = 0; guard = 0; pc = sr_clk_w[0];
      while (rises < 4 && guard < 300) begin
        @(negedge clk);
        if (sr_clk_w[0] && !pc) rises++;
        pc = sr_clk_w[0];
        guard++;
      end
      chk("t4_reach_hi4", 0, rises, 4);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("t4_outs_low", 0, {sr_data_w[0], sr_clk_w[0], sr_latch_w[0], err_w[0]}, 0);
      chk("t4_busy", 0, busy_w[0], 0);
      chk("t4_ready", 0, ready_w[0], 1);
      rst_n = 1'b1;
      lw = 0;
      repeat (100) begin
        @(negedge clk);
        if (sr_latch_w[0]) lw++;
      end
      chk("t4_no_latch", 0, lw, 0);
      chk("t4_frames_unchanged", 0, obs0.size(), 8);
    end

    // Random traffic on both instances with occasional one-cycle resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 799) != 0);
      for (int g = 0; g < 2; g++) begin
        valid_s[g] = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
        cmd_s[g]   = 8'($urandom);
      end
    end
    @(negedge clk);
    rst_n   = 1'b1;
    valid_s = '0;
    wait_idle(0, 3000, "rand_drain");
    wait_idle(1, 3000, "rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
